i2c_bus_arbiter: RTL
====================

Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master engine between NUM_REQ requesters.
- Grants requesters round-robin and holds the grant for a whole transaction.
- Sequences each transaction as START, address+R/W byte, LEN data bytes, then STOP, issuing one engine command at a time.
- Sits between the Wishbone-side command sources and the I2C master engine that drives scl/sda.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
I2C_ADDR_WIDTH, 7, slave address width
I2C_DATA_WIDTH, 8, data byte width
LEN_WIDTH, 4, byte-count width; LEN=0 means address-only probe
WDT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  NUM_REQ  per-requester transaction request, level
req_addr_i  in  NUM_REQ*I2C_ADDR_WIDTH  packed slave addresses, requester k at slice k
req_op_i  in  NUM_REQ  1=READ, 0=WRITE (i2c_op_t encoding)
req_len_i  in  NUM_REQ*LEN_WIDTH  packed byte counts
gnt_o  out  NUM_REQ  one-hot grant, held for the full transaction
wdata_i  in  I2C_DATA_WIDTH  write byte, driven by the granted requester
wdata_ready_o  out  1  1-cycle pulse: wdata_i consumed
rdata_o  out  I2C_DATA_WIDTH  read byte
rdata_valid_o  out  1  1-cycle pulse per read byte
done_o  out  1  1-cycle pulse when the transaction ends (after STOP)
err_o  out  1  valid with done_o: NAK received or watchdog abort
eng_cmd_o  out  3  engine command (i2c_eng_cmd_t)
eng_cmd_valid_o  out  1  command valid, held until eng_done_i
eng_wdata_o  out  I2C_DATA_WIDTH  byte for WRITE commands
eng_done_i  in  1  1-cycle pulse: current command complete
eng_nak_i  in  1  valid with eng_done_i for WRITE: slave NAKed
eng_rdata_i  in  I2C_DATA_WIDTH  valid with eng_done_i for READ commands

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; RR pointer = 0; byte counter = 0. A reset mid-transaction drops eng_cmd_valid_o the next cycle with no STOP; the engine shares rst_i.
- States: IDLE, START, ADDR, WR, RD, STOP, DONE.
- IDLE:
  - If any req_i is high, pick the first requester at or after the pointer, modulo NUM_REQ.
  - Register gnt_o, address, op and len for that requester.
  - Go to START. Grant latency is 1 cycle from req_i.
- Every command state:
  - Assert eng_cmd_valid_o and a stable eng_cmd_o on state entry.
  - Hold both until the cycle eng_done_i is sampled.
  - Drop eng_cmd_valid_o the cycle after eng_done_i; the next command asserts in that same cycle.
  - eng_done_i while eng_cmd_valid_o=0 is ignored.
- START: issue CMD_START, then go to ADDR.
- ADDR: issue CMD_WRITE with eng_wdata_o = {addr, op}.
  - NAK: set the error flag and go to STOP.
  - ACK with len=0: go to STOP.
  - ACK otherwise: go to WR or RD by op.
- WR:
  - On entry, capture wdata_i into eng_wdata_o and pulse wdata_ready_o in the same cycle.
  - On done, decrement the counter.
  - NAK: set the error flag and go to STOP. This is an early stop; remaining bytes are not requested.
  - Counter reaches 0: go to STOP.
  - Otherwise re-enter WR.
- RD:
  - Issue CMD_READ_ACK, or CMD_READ_NAK when the counter is 1.
  - On done, rdata_o = eng_rdata_i and pulse rdata_valid_o.
  - Decrement the counter; at 0 go to STOP.
- STOP: issue CMD_STOP, then go to DONE.
- DONE:
  - Pulse done_o, with err_o = error flag.
  - Clear gnt_o.
  - Set the pointer to granted index + 1, wrapping NUM_REQ-1 to 0.
  - Go to IDLE. A new grant is possible on the next cycle.
- Requests:
  - req_i deassertion mid-transaction is ignored; the transaction completes.
  - req_i changes on non-granted lines never affect the current grant.
- Width rules:
  - The counter is LEN_WIDTH bits and never underflows.
  - Maximum transfer is 2^LEN_WIDTH-1 bytes.

Optional Feature:
- Macro: I2C_BUS_ARBITER_WATCHDOG_EN.
- With the macro defined:
  - A counter runs while eng_cmd_valid_o=1 and clears on each eng_done_i.
  - Reaching WDT_CYCLES: drop eng_cmd_valid_o, pulse done_o with err_o=1, advance the pointer, return to IDLE. No STOP is issued.
- Without the macro: no counter; the FSM waits for eng_done_i indefinitely.
- WDT_CYCLES is then unused.

Decomposition:
- types_pkg gets i2c_eng_cmd_t: CMD_START=0, CMD_STOP=1, CMD_WRITE=2, CMD_READ_ACK=3, CMD_READ_NAK=4.
- types_pkg also gets i2c_arb_state_t; it reuses the existing i2c_op_t.
- One sub-module, i2c_rr_arbiter: purely combinational one-hot round-robin pick from req vector and pointer.

Test Plan:
- Write: req_i=0001, addr 0x22, WRITE, len=2, wdata 0xA5 then 0x5A → engine sees START, WRITE 0x44, WRITE 0xA5, WRITE 0x5A, STOP. Two wdata_ready_o pulses; done_o=1, err_o=0.
- Read: req 0x22 READ len=3 → WRITE 0x45, READ_ACK, READ_ACK, READ_NAK, STOP. Three rdata_valid_o pulses carrying the engine bytes 0x11, 0x22, 0x33.
- Address NAK: eng_nak_i=1 on the address byte → no data commands, STOP issued, done_o with err_o=1.
- Round-robin: req_i=1111 held for 5 transactions → gnt_o sequence 0001, 0010, 0100, 1000, 0001.
- Reset mid-WR: rst_i on the 2nd data byte → next cycle all outputs 0; req_i=0100 then gets gnt_o=0100, because the pointer reset to 0.
- Watchdog (macro on, WDT_CYCLES=16): engine never returns done after START → done_o and err_o pulse 16 cycles after eng_cmd_valid_o rises, with no STOP issued.

Source files
------------

// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the I2C bus arbiter: bus operation, engine command and FSM state encodings.
package i2c_bus_arbiter_pkg;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2c_eng_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WR    = 3'd3,
    ST_RD    = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } i2c_arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Command/response link between the arbiter (master) and the byte-level I2C engine (slave).
interface i2c_bus_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  import i2c_bus_arbiter_pkg::*;

  i2c_eng_cmd_t          eng_cmd;
  logic                  eng_cmd_valid;
  logic [DATA_WIDTH-1:0] eng_wdata;
  logic                  eng_done;
  logic                  eng_nak;
  logic [DATA_WIDTH-1:0] eng_rdata;

  modport master (
    output eng_cmd, eng_cmd_valid, eng_wdata,
    input  eng_done, eng_nak, eng_rdata
  );

  modport slave (
    input  eng_cmd, eng_cmd_valid, eng_wdata,
    output eng_done, eng_nak, eng_rdata
  );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping modulo NUM_REQ.
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  int               w_pos;
  logic [PTR_W-1:0] w_sel;

  // Scan from the farthest offset down so the nearest hit to the pointer wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    w_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_sel = PTR_W'(w_pos);
      if (i_req[w_sel]) begin
        o_gnt   = NUM_REQ'(1) << w_sel;
        o_idx   = w_sel;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sequencing START/ADDR/DATA/STOP commands into one shared I2C byte engine.
// Optional command watchdog: define I2C_BUS_ARBITER_WATCHDOG_EN.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 4,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]                req_op_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  input  logic [I2C_DATA_WIDTH-1:0]         wdata_i,
  output logic                              wdata_ready_o,
  output logic [I2C_DATA_WIDTH-1:0]         rdata_o,
  output logic                              rdata_valid_o,
  output logic                              done_o,
  output logic                              err_o,
  i2c_bus_arbiter_if.master                 eng
);

  localparam int PTR_W = $clog2(NUM_REQ);

  i2c_arb_state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]            r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]            r_idx, w_idx_nxt;
  logic [NUM_REQ-1:0]          r_gnt, w_gnt_nxt;
  logic [I2C_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  i2c_op_t                     r_op, w_op_nxt;
  logic [LEN_WIDTH-1:0]        r_cnt, w_cnt_nxt;
  logic                        r_err_flag, w_err_flag_nxt;
  i2c_eng_cmd_t                r_cmd, w_cmd_nxt;
  logic                        r_cmd_valid, w_cmd_valid_nxt;
  logic [I2C_DATA_WIDTH-1:0]   r_eng_wdata, w_eng_wdata_nxt;
  logic [I2C_DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic                        r_wdata_ready, w_wdata_ready_nxt;
  logic                        r_rdata_valid, w_rdata_valid_nxt;
  logic                        r_done, w_done_nxt;
  logic                        r_err, w_err_nxt;

  logic [NUM_REQ-1:0]          w_rr_gnt;
  logic [PTR_W-1:0]            w_rr_idx;
  logic                        w_rr_valid;
  logic                        w_cmd_done;
  logic                        w_wdt_expire;

  i2c_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  // A completion only counts while a command is actually outstanding.
  assign w_cmd_done = r_cmd_valid & eng.eng_done;

`ifdef I2C_BUS_ARBITER_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !r_cmd_valid || eng.eng_done) r_wdt <= '0;
    else                                       r_wdt <= r_wdt + 1'b1;
  end

  assign w_wdt_expire = r_cmd_valid && !eng.eng_done && (r_wdt == WDT_W'(WDT_CYCLES - 1));
`else
  assign w_wdt_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_idx_nxt         = r_idx;
    w_gnt_nxt         = r_gnt;
    w_addr_nxt        = r_addr;
    w_op_nxt          = r_op;
    w_cnt_nxt         = r_cnt;
    w_err_flag_nxt    = r_err_flag;
    w_cmd_nxt         = r_cmd;
    w_cmd_valid_nxt   = r_cmd_valid;
    w_eng_wdata_nxt   = r_eng_wdata;
    w_rdata_nxt       = r_rdata;
    w_wdata_ready_nxt = 1'b0;
    w_rdata_valid_nxt = 1'b0;
    w_done_nxt        = 1'b0;
    w_err_nxt         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rr_valid) begin
          w_gnt_nxt       = w_rr_gnt;
          w_idx_nxt       = w_rr_idx;
          w_addr_nxt      = req_addr_i[w_rr_idx*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
          w_op_nxt        = i2c_op_t'(req_op_i[w_rr_idx]);
          w_cnt_nxt       = req_len_i[w_rr_idx*LEN_WIDTH +: LEN_WIDTH];
          w_err_flag_nxt  = 1'b0;
          w_state_nxt     = ST_START;
          w_cmd_nxt       = CMD_START;
          w_cmd_valid_nxt = 1'b1;
        end
      end

      ST_START: begin
        if (w_cmd_done) begin
          w_state_nxt     = ST_ADDR;
          w_cmd_nxt       = CMD_WRITE;
          w_eng_wdata_nxt = I2C_DATA_WIDTH'({r_addr, r_op});
        end
      end

      ST_ADDR: begin
        if (w_cmd_done) begin
          if (eng.eng_nak || r_cnt == '0) begin
            w_err_flag_nxt = eng.eng_nak;
            w_state_nxt    = ST_STOP;
            w_cmd_nxt      = CMD_STOP;
          end else if (r_op == OP_READ) begin
            w_state_nxt = ST_RD;
            w_cmd_nxt   = (r_cnt == LEN_WIDTH'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
          end else begin
            w_state_nxt       = ST_WR;
            w_cmd_nxt         = CMD_WRITE;
            w_eng_wdata_nxt   = wdata_i;
            w_wdata_ready_nxt = 1'b1;
          end
        end
      end

      ST_WR: begin
        if (w_cmd_done) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (eng.eng_nak || r_cnt == LEN_WIDTH'(1)) begin
            w_err_flag_nxt = r_err_flag | eng.eng_nak;
            w_state_nxt    = ST_STOP;
            w_cmd_nxt      = CMD_STOP;
          end else begin
            w_eng_wdata_nxt   = wdata_i;
            w_wdata_ready_nxt = 1'b1;
          end
        end
      end

      ST_RD: begin
        if (w_cmd_done) begin
          w_rdata_nxt       = eng.eng_rdata;
          w_rdata_valid_nxt = 1'b1;
          w_cnt_nxt         = r_cnt - 1'b1;
          if (r_cnt == LEN_WIDTH'(1)) begin
            w_state_nxt = ST_STOP;
            w_cmd_nxt   = CMD_STOP;
          end else begin
            // The last byte of a read is NAKed so the slave releases SDA before STOP.
            w_cmd_nxt = (r_cnt == LEN_WIDTH'(2)) ? CMD_READ_NAK : CMD_READ_ACK;
          end
        end
      end

      ST_STOP: begin
        if (w_cmd_done) begin
          w_state_nxt     = ST_DONE;
          w_cmd_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_err_nxt       = r_err_flag;
        end
      end

      ST_DONE: begin
        w_gnt_nxt   = '0;
        w_ptr_nxt   = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_valid_nxt = 1'b0;
        w_gnt_nxt       = '0;
      end
    endcase

    // Watchdog abort skips STOP; DONE still releases the grant and advances the pointer.
    if (w_wdt_expire) begin
      w_state_nxt     = ST_DONE;
      w_cmd_valid_nxt = 1'b0;
      w_done_nxt      = 1'b1;
      w_err_nxt       = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_gnt         <= '0;
      r_addr        <= '0;
      r_op          <= OP_WRITE;
      r_cnt         <= '0;
      r_err_flag    <= 1'b0;
      r_cmd         <= CMD_START;
      r_cmd_valid   <= 1'b0;
      r_eng_wdata   <= '0;
      r_rdata       <= '0;
      r_wdata_ready <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_idx         <= w_idx_nxt;
      r_gnt         <= w_gnt_nxt;
      r_addr        <= w_addr_nxt;
      r_op          <= w_op_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err_flag    <= w_err_flag_nxt;
      r_cmd         <= w_cmd_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_eng_wdata   <= w_eng_wdata_nxt;
      r_rdata       <= w_rdata_nxt;
      r_wdata_ready <= w_wdata_ready_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign gnt_o             = r_gnt;
  assign wdata_ready_o     = r_wdata_ready;
  assign rdata_o           = r_rdata;
  assign rdata_valid_o     = r_rdata_valid;
  assign done_o            = r_done;
  assign err_o             = r_err;
  assign eng.eng_cmd       = r_cmd;
  assign eng.eng_cmd_valid = r_cmd_valid;
  assign eng.eng_wdata     = r_eng_wdata;

endmodule
